lea_data_bus_reader: RTL

- Read-side master for a bank of NrOfRegs learned-data registers that share one tri-state data bus.
- Each register drives the bus only while its cs bit is 0 and floats the bus (high-Z) while its cs bit is 1.
- On Start, the block selects each register in turn, waits a settle interval, samples the bus and presents the word on a valid/ready stream to the inference datapath.
- Guarantees that at most one register drives the bus at any time, with at least one all-deselected cycle between selections.

---
 rtl/lea_data_bus_reader_if.sv | 42 ++++
 rtl/lea_data_bus_reader.sv | 156 +++++++++++++++
 2 files changed

// File: rtl/lea_data_bus_reader_if.sv
// rtl/lea_data_bus_reader_if.sv - Control and stream signals of the learned-data bus reader.
//
// Purpose: groups the scan control, shared bus, chip selects and the output
// word stream of lea_data_bus_reader into one bundle.
// Signals:
//   start      - one-cycle request to begin a full scan
//   abort      - synchronous abort back to idle
//   bus        - shared tri-state data bus, read side
//   cs         - per-register chip select, active low (0 = register drives bus)
//   data_out   - sampled word
//   data_idx   - index of the register data_out came from
//   data_valid - data_out/data_idx valid
//   data_ready - consumer accepts the word on data_valid & data_ready
//   busy       - scan in progress
//   done       - one-cycle pulse after the last word is accepted
// Modports: master = the reader, slave = registers/consumer side.
interface lea_data_bus_reader_if #(
    parameter int NrOfBits = 8,
    parameter int NrOfRegs = 16,
    parameter int IdxBits  = 4
);
    logic                start;
    logic                abort;
    logic [NrOfBits-1:0] bus;
    logic [NrOfRegs-1:0] cs;
    logic [NrOfBits-1:0] data_out;
    logic [IdxBits-1:0]  data_idx;
    logic                data_valid;
    logic                data_ready;
    logic                busy;
    logic                done;

    modport master (
        input  start, abort, bus, data_ready,
        output cs, data_out, data_idx, data_valid, busy, done
    );

    modport slave (
        output start, abort, bus, data_ready,
        input  cs, data_out, data_idx, data_valid, busy, done
    );
endinterface

// File: rtl/lea_data_bus_reader.sv
// rtl/lea_data_bus_reader.sv - Read-side master scanning a bank of registers on a shared tri-state bus.
//
// Purpose: on start, selects each register in turn (cs low), waits
// SettleCycles extra cycles, samples the bus and offers the word on a
// valid/ready stream. Between any two selections cs is all ones for at least
// one cycle, so no two registers ever drive the bus together.
// Ports:
//   clk   - system clock, rising edge
//   rst_n - asynchronous active-low reset
//   io    - lea_data_bus_reader_if.master (start/abort/bus/cs/stream/busy/done)
module lea_data_bus_reader #(
    parameter int NrOfBits     = 8,
    parameter int NrOfRegs     = 16,
    parameter int IdxBits      = 4,
    parameter int SettleCycles = 1
) (
    input  logic                   clk,
    input  logic                   rst_n,
    lea_data_bus_reader_if.master  io
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_SELECT,
        S_HOLD,
        S_DONE
    } state_t;

    localparam logic [NrOfRegs-1:0] CsNone   = '1;
    localparam logic [IdxBits-1:0]  LastIdx  = IdxBits'(NrOfRegs - 1);
    localparam logic [2:0]          SettleLast = 3'(SettleCycles);

    state_t              state_q, state_d;
    logic [IdxBits-1:0]  idx_q, idx_d;
    logic [2:0]          cnt_q, cnt_d;
    logic [NrOfRegs-1:0] cs_q, cs_d;
    logic [NrOfBits-1:0] data_out_q, data_out_d;
    logic [IdxBits-1:0]  data_idx_q, data_idx_d;
    logic                data_valid_q, data_valid_d;
    logic                busy_q, busy_d;
    logic                done_q, done_d;

    // Chip-select pattern with only the bit of the given register low.
    function automatic logic [NrOfRegs-1:0] sel_cs(input logic [IdxBits-1:0] idx);
        logic [NrOfRegs-1:0] one;
        one    = '0;
        one[0] = 1'b1;
        return ~(one << idx);
    endfunction

    always_comb begin
        state_d      = state_q;
        idx_d        = idx_q;
        cnt_d        = cnt_q;
        cs_d         = cs_q;
        data_out_d   = data_out_q;
        data_idx_d   = data_idx_q;
        data_valid_d = data_valid_q;
        busy_d       = busy_q;
        done_d       = 1'b0;

        case (state_q)
            S_IDLE: begin
                cs_d   = CsNone;
                busy_d = 1'b0;
                if (io.start) begin
                    state_d = S_SELECT;
                    idx_d   = '0;
                    cnt_d   = '0;
                    cs_d    = sel_cs('0);
                    busy_d  = 1'b1;
                end
            end
            S_SELECT: begin
                if (cnt_q == SettleLast) begin
                    // Final selected cycle: capture the bus and release it in
                    // the same edge, which opens the turnaround gap.
                    data_out_d   = io.bus;
                    data_idx_d   = idx_q;
                    data_valid_d = 1'b1;
                    cs_d         = CsNone;
                    cnt_d        = '0;
                    state_d      = S_HOLD;
                end else begin
                    cnt_d = cnt_q + 3'd1;
                end
            end
            S_HOLD: begin
                if (data_valid_q && io.data_ready) begin
                    data_valid_d = 1'b0;
                    if (idx_q == LastIdx) begin
                        state_d = S_DONE;
                        done_d  = 1'b1;
                    end else begin
                        idx_d   = idx_q + 1'b1;
                        cs_d    = sel_cs(idx_q + 1'b1);
                        cnt_d   = '0;
                        state_d = S_SELECT;
                    end
                end
            end
            S_DONE: begin
                busy_d  = 1'b0;
                idx_d   = '0;
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
                cs_d    = CsNone;
            end
        endcase

        // Abort wins over start and over a handshake in the same cycle.
        if (io.abort) begin
            state_d      = S_IDLE;
            idx_d        = '0;
            cnt_d        = '0;
            cs_d         = CsNone;
            data_valid_d = 1'b0;
            busy_d       = 1'b0;
            done_d       = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= S_IDLE;
            idx_q        <= '0;
            cnt_q        <= '0;
            cs_q         <= CsNone;
            data_out_q   <= '0;
            data_idx_q   <= '0;
            data_valid_q <= 1'b0;
            busy_q       <= 1'b0;
            done_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            idx_q        <= idx_d;
            cnt_q        <= cnt_d;
            cs_q         <= cs_d;
            data_out_q   <= data_out_d;
            data_idx_q   <= data_idx_d;
            data_valid_q <= data_valid_d;
            busy_q       <= busy_d;
            done_q       <= done_d;
        end
    end

    assign io.cs         = cs_q;
    assign io.data_out   = data_out_q;
    assign io.data_idx   = data_idx_q;
    assign io.data_valid = data_valid_q;
    assign io.busy       = busy_q;
    assign io.done       = done_q;

endmodule
